prefetch_tracker: RTL and testbench

Front-end fetch-pointer stage that sits directly upstream of `prefetch_control`. It holds the current linear fetch address, the CS-limit budget and the fetch privilege. From these it drives `prefetch_address`, `prefetch_length` and `prefetch_su`. It advances on every icache delivery and pushes one-shot limit-fault or page-fault markers into the prefetch FIFO, so decode sees the fault in stream order.

---
 rtl/prefetch_tracker.sv | 93 +++++++++
 tb/tb_prefetch_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prefetch_tracker.sv
// Fetch-pointer stage: tracks linear fetch address, CS-limit budget and privilege,
// and emits one-shot limit / page-fault markers into the prefetch FIFO.
module prefetch_tracker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pr_reset,
  input  logic [31:0] prefetch_eip,
  input  logic [31:0] cs_base,
  input  logic [31:0] cs_limit,
  input  logic [1:0]  prefetch_cpl,
  input  logic        prefetched_do,
  input  logic [4:0]  prefetched_length,
  input  logic        tlbcode_pagefault,
  output logic [31:0] prefetch_address,
  output logic [4:0]  prefetch_length,
  output logic        prefetch_su,
  output logic        prefetchfifo_signal_limit_do,
  output logic        prefetchfifo_signal_pf_do
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    LIMIT_DONE = 2'd2,
    FAULT_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] linear_q;
  logic [32:0] left_q;
  logic        su_q;
  logic        limit_pulse_q;
  logic        pf_pulse_q;

  logic [32:0] redirect_left_d;
  logic [32:0] deliver_len;

  // 33-bit budget so a full 4 GiB segment (limit 0xFFFFFFFF, eip 0) is representable.
  assign redirect_left_d = (prefetch_eip > cs_limit) ? 33'd0
                         : {1'b0, cs_limit} - {1'b0, prefetch_eip} + 33'd1;
  assign deliver_len     = {28'd0, prefetched_length};

  // NOTE: every state register uses non-blocking assignment so all flops sample
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      linear_q      <= 32'd0;
      left_q        <= 33'd0;
      su_q          <= 1'b0;
      limit_pulse_q <= 1'b0;
      pf_pulse_q    <= 1'b0;
    end else begin
      limit_pulse_q <= 1'b0;
      pf_pulse_q    <= 1'b0;
      if (pr_reset) begin
        linear_q <= cs_base + prefetch_eip;
        left_q   <= redirect_left_d;
        su_q     <= (prefetch_cpl == 2'd3);
        state_q  <= FETCH;
      end else begin
        case (state_q)
          FETCH: begin
            if (tlbcode_pagefault) begin
              pf_pulse_q <= 1'b1;
              state_q    <= FAULT_DONE;
            end else if (left_q == 33'd0) begin
              limit_pulse_q <= 1'b1;
              state_q       <= LIMIT_DONE;
            end else if (prefetched_do && (prefetched_length != 5'd0)) begin
              linear_q <= linear_q + {27'd0, prefetched_length};
              left_q   <= (deliver_len > left_q) ? 33'd0 : left_q - deliver_len;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    prefetch_length = 5'd0;
    if (state_q == FETCH)
      prefetch_length = (left_q >= 33'd16) ? 5'd16 : left_q[4:0];
  end

  assign prefetch_address             = linear_q;
  assign prefetch_su                  = su_q;
  assign prefetchfifo_signal_limit_do = limit_pulse_q;
  assign prefetchfifo_signal_pf_do    = pf_pulse_q;

endmodule

// File: tb/tb_prefetch_tracker.sv
// Directed bench for prefetch_tracker: redirect, advance, limit, page fault,
// wrap, simultaneous events and asynchronous reset.
module tb_prefetch_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pr_reset;
  logic [31:0] prefetch_eip;
  logic [31:0] cs_base;
  logic [31:0] cs_limit;
  logic [1:0]  prefetch_cpl;
  logic        prefetched_do;
  logic [4:0]  prefetched_length;
  logic        tlbcode_pagefault;
  logic [31:0] prefetch_address;
  logic [4:0]  prefetch_length;
  logic        prefetch_su;
  logic        limit_do;
  logic        pf_do;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prefetch_tracker dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .pr_reset                     (pr_reset),
    .prefetch_eip                 (prefetch_eip),
    .cs_base                      (cs_base),
    .cs_limit                     (cs_limit),
    .prefetch_cpl                 (prefetch_cpl),
    .prefetched_do                (prefetched_do),
    .prefetched_length            (prefetched_length),
    .tlbcode_pagefault            (tlbcode_pagefault),
    .prefetch_address             (prefetch_address),
    .prefetch_length              (prefetch_length),
    .prefetch_su                  (prefetch_su),
    .prefetchfifo_signal_limit_do (limit_do),
    .prefetchfifo_signal_pf_do    (pf_do)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] base, input logic [31:0] eip,
                          input logic [31:0] limit, input logic [1:0] cpl);
    cs_base      = base;
    prefetch_eip = eip;
    cs_limit     = limit;
    prefetch_cpl = cpl;
    pr_reset     = 1'b1;
    tick();
    pr_reset     = 1'b0;
  endtask

  task automatic deliver(input logic [4:0] len);
    prefetched_do     = 1'b1;
    prefetched_length = len;
    tick();
    prefetched_do     = 1'b0;
    prefetched_length = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    rst_n = 1'b0; pr_reset = 1'b0; prefetch_eip = '0; cs_base = '0; cs_limit = '0;
    prefetch_cpl = '0; prefetched_do = 1'b0; prefetched_length = '0; tlbcode_pagefault = 1'b0;
    repeat (3) tick();
    check("rst_addr", prefetch_address, 32'h0);
    check("rst_len", {27'd0, prefetch_length}, 32'd0);
    check("rst_su", {31'd0, prefetch_su}, 32'd0);
    check("rst_limit", {31'd0, limit_do}, 32'd0);
    check("rst_pf", {31'd0, pf_do}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_len", {27'd0, prefetch_length}, 32'd0);

    // Redirect with a large limit, user privilege.
    redirect(32'h0001_0000, 32'h100, 32'hFFFF, 2'd3);
    check("r1_addr", prefetch_address, 32'h0001_0100);
    check("r1_len", {27'd0, prefetch_length}, 32'd16);
    check("r1_su", {31'd0, prefetch_su}, 32'd1);
    check("r1_limit", {31'd0, limit_do}, 32'd0);
    check("r1_pf", {31'd0, pf_do}, 32'd0);

    // Advance up to the limit: left = 16.
    redirect(32'h0, 32'hFFF0, 32'hFFFF, 2'd0);
    check("a_addr0", prefetch_address, 32'hFFF0);
    check("a_len0", {27'd0, prefetch_length}, 32'd16);
    check("a_su0", {31'd0, prefetch_su}, 32'd0);
    deliver(5'd10);
    check("a_addr1", prefetch_address, 32'hFFFA);
    check("a_len1", {27'd0, prefetch_length}, 32'd6);
    deliver(5'd6);
    check("a_addr2", prefetch_address, 32'h0001_0000);
    check("a_len2", {27'd0, prefetch_length}, 32'd0);
    check("a_limit_early", {31'd0, limit_do}, 32'd0);
    tick();
    check("a_limit_pulse", {31'd0, limit_do}, 32'd1);
    check("a_len3", {27'd0, prefetch_length}, 32'd0);
    tick();
    check("a_limit_clear", {31'd0, limit_do}, 32'd0);
    deliver(5'd5);
    check("a_ignored_addr", prefetch_address, 32'h0001_0000);
    check("a_limit_once", {31'd0, limit_do}, 32'd0);

    // EIP beyond limit.
    redirect(32'h0, 32'h2000, 32'h1FFF, 2'd0);
    check("b_addr", prefetch_address, 32'h2000);
    check("b_len", {27'd0, prefetch_length}, 32'd0);
    check("b_limit_n1", {31'd0, limit_do}, 32'd0);
    tick();
    check("b_limit_n2", {31'd0, limit_do}, 32'd1);
    // Redirect while the pulse is high: pulse completes, then clears.
    redirect(32'h0, 32'h10, 32'hFF, 2'd0);
    check("b_limit_after_redir", {31'd0, limit_do}, 32'd0);
    check("b_len_after_redir", {27'd0, prefetch_length}, 32'd16);
    check("b_addr_after_redir", prefetch_address, 32'h10);

    // Page fault while fetching.
    redirect(32'h0, 32'h100, 32'hFFFF, 2'd0);
    tlbcode_pagefault = 1'b1;
    tick();
    tlbcode_pagefault = 1'b0;
    check("pf_pulse", {31'd0, pf_do}, 32'd1);
    check("pf_len", {27'd0, prefetch_length}, 32'd0);
    check("pf_nolimit", {31'd0, limit_do}, 32'd0);
    tick();
    check("pf_clear", {31'd0, pf_do}, 32'd0);
    deliver(5'd8);
    check("pf_ignored_addr", prefetch_address, 32'h100);
    check("pf_ignored_len", {27'd0, prefetch_length}, 32'd0);
    check("pf_once", {31'd0, pf_do}, 32'd0);

    // Full 4 GiB segment with address wrap.
    redirect(32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFFF, 2'd3);
    check("w_addr0", prefetch_address, 32'hFFFF_FFF8);
    check("w_len0", {27'd0, prefetch_length}, 32'd16);
    deliver(5'd16);
    check("w_addr1", prefetch_address, 32'h0000_0008);
    check("w_len1", {27'd0, prefetch_length}, 32'd16);

    // Redirect together with delivery and page fault: only redirect acts.
    cs_base = 32'h0; prefetch_eip = 32'h40; cs_limit = 32'hFF; prefetch_cpl = 2'd0;
    pr_reset = 1'b1; prefetched_do = 1'b1; prefetched_length = 5'd4; tlbcode_pagefault = 1'b1;
    tick();
    pr_reset = 1'b0; prefetched_do = 1'b0; prefetched_length = 5'd0; tlbcode_pagefault = 1'b0;
    check("s_addr", prefetch_address, 32'h40);
    check("s_len", {27'd0, prefetch_length}, 32'd16);
    check("s_su", {31'd0, prefetch_su}, 32'd0);
    check("s_pf", {31'd0, pf_do}, 32'd0);
    tick();
    check("s_pf_next", {31'd0, pf_do}, 32'd0);
    check("s_addr_next", prefetch_address, 32'h40);

    // Asynchronous reset mid-FETCH.
    redirect(32'h1000, 32'h20, 32'hFFFF, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_addr", prefetch_address, 32'h0);
    check("ar_len", {27'd0, prefetch_length}, 32'd0);
    check("ar_su", {31'd0, prefetch_su}, 32'd0);
    check("ar_limit", {31'd0, limit_do}, 32'd0);
    check("ar_pf", {31'd0, pf_do}, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (2) tick();
    check("ar_idle_len", {27'd0, prefetch_length}, 32'd0);
    check("ar_idle_limit", {31'd0, limit_do}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
